// File: rtl/pwm_pkg.sv
// Shared definitions for the PWM dead-time array.
// Holds the per-channel state encoding and the default width constants
// used as parameter defaults by pwm_deadtime_array and pwm_dt_channel.
package pwm_pkg;

    localparam int unsigned PWM_N_CH_DEF       = 2;
    localparam int unsigned PWM_DATA_WIDTH_DEF = 16;
    localparam int unsigned PWM_DT_WIDTH_DEF   = 10;

    // Channel state; OFF and DEAD both drive the bridge fully off.
    typedef enum logic [1:0] {
        ST_OFF  = 2'd0,
        ST_HIGH = 2'd1,
        ST_LOW  = 2'd2,
        ST_DEAD = 2'd3
    } ch_state_e;

endpackage : pwm_pkg

// File: rtl/pwm_dt_channel.sv
// One H-bridge leg: optional min-pulse filter, dead-time counter and the
// OFF/HIGH/LOW/DEAD state machine with registered gate drives.
//
// Configuration macro: PWM_MIN_PULSE_EN adds the min_pulse port and the
// raw glitch filter; without it every raw change is accepted at once.
//
// Ports:
//   clk, rst       clock, asynchronous active-high reset
//   force_off      disable or fault; sends the channel to OFF next edge
//   raw            registered compare result (1 = high side wanted)
//   deadtime       dead-time length in clk cycles, sampled on DEAD entry
//   min_pulse      minimum accepted raw pulse width (PWM_MIN_PULSE_EN only)
//   pwm_high       high-side gate drive
//   pwm_low        low-side gate drive
//   dt_active      channel is in DEAD
module pwm_dt_channel
    import pwm_pkg::*;
#(
    parameter int unsigned DT_WIDTH = PWM_DT_WIDTH_DEF
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                force_off,
    input  logic                raw,
    input  logic [DT_WIDTH-1:0] deadtime,
`ifdef PWM_MIN_PULSE_EN
    input  logic [DT_WIDTH-1:0] min_pulse,
`endif
    output logic                pwm_high,
    output logic                pwm_low,
    output logic                dt_active
);

    // Raw value the state machine acts on (after optional filtering).
    logic acc_c;

`ifdef PWM_MIN_PULSE_EN
    localparam int unsigned CW = DT_WIDTH + 1;

    logic                acc_q;
    logic [DT_WIDTH-1:0] hold_q;

    // Count consecutive cycles raw disagrees with the accepted value; adopt
    // raw once it has held for min_pulse cycles. While forced off the
    // accepted value simply follows raw so start-up sees no stale level.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc_q  <= 1'b0;
            hold_q <= '0;
        end else if (force_off || (raw == acc_q)) begin
            acc_q  <= raw;
            hold_q <= '0;
        end else if ((CW'(hold_q) + CW'(1)) >= CW'(min_pulse)) begin
            acc_q  <= raw;
            hold_q <= '0;
        end else begin
            hold_q <= hold_q + DT_WIDTH'(1);
        end
    end

    // min_pulse of 0 or 1 bypasses the filter with no added latency.
    assign acc_c = (min_pulse <= DT_WIDTH'(1)) ? raw : acc_q;
`else
    assign acc_c = raw;
`endif

    ch_state_e           state_q;
    logic                target_q;
    logic [DT_WIDTH-1:0] dt_cnt_q;
    // Dead-time captured on DEAD entry so a mid-DEAD change of deadtime
    // (including on reloads) only applies to the next entry.
    logic [DT_WIDTH-1:0] dt_len_q;

    // Channel state machine; drives are updated together with the state so
    // they always decode the registered state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_OFF;
            target_q  <= 1'b0;
            dt_cnt_q  <= '0;
            dt_len_q  <= '0;
            pwm_high  <= 1'b0;
            pwm_low   <= 1'b0;
            dt_active <= 1'b0;
        end else if (force_off) begin
            state_q   <= ST_OFF;
            target_q  <= 1'b0;
            dt_cnt_q  <= '0;
            dt_len_q  <= '0;
            pwm_high  <= 1'b0;
            pwm_low   <= 1'b0;
            dt_active <= 1'b0;
        end else begin
            case (state_q)
                ST_OFF: begin
                    // Always start through DEAD toward the current raw level.
                    state_q   <= ST_DEAD;
                    target_q  <= acc_c;
                    dt_cnt_q  <= deadtime;
                    dt_len_q  <= deadtime;
                    pwm_high  <= 1'b0;
                    pwm_low   <= 1'b0;
                    dt_active <= 1'b1;
                end
                ST_HIGH: begin
                    if (!acc_c) begin
                        if (deadtime == '0) begin
                            state_q  <= ST_LOW;
                            pwm_high <= 1'b0;
                            pwm_low  <= 1'b1;
                        end else begin
                            state_q   <= ST_DEAD;
                            target_q  <= 1'b0;
                            dt_cnt_q  <= deadtime;
                            dt_len_q  <= deadtime;
                            pwm_high  <= 1'b0;
                            pwm_low   <= 1'b0;
                            dt_active <= 1'b1;
                        end
                    end
                end
                ST_LOW: begin
                    if (acc_c) begin
                        if (deadtime == '0) begin
                            state_q  <= ST_HIGH;
                            pwm_high <= 1'b1;
                            pwm_low  <= 1'b0;
                        end else begin
                            state_q   <= ST_DEAD;
                            target_q  <= 1'b1;
                            dt_cnt_q  <= deadtime;
                            dt_len_q  <= deadtime;
                            pwm_high  <= 1'b0;
                            pwm_low   <= 1'b0;
                            dt_active <= 1'b1;
                        end
                    end
                end
                ST_DEAD: begin
                    if (acc_c != target_q) begin
                        // Direction reversed while dead: restart the interval.
                        target_q <= acc_c;
                        dt_cnt_q <= dt_len_q;
                    end else if (dt_cnt_q <= DT_WIDTH'(1)) begin
                        state_q   <= target_q ? ST_HIGH : ST_LOW;
                        pwm_high  <= target_q;
                        pwm_low   <= !target_q;
                        dt_active <= 1'b0;
                    end else begin
                        dt_cnt_q <= dt_cnt_q - DT_WIDTH'(1);
                    end
                end
                default: begin
                    state_q   <= ST_OFF;
                    pwm_high  <= 1'b0;
                    pwm_low   <= 1'b0;
                    dt_active <= 1'b0;
                end
            endcase
        end
    end

endmodule : pwm_dt_channel

// File: rtl/pwm_deadtime_array.sv
// Array of N_CH carrier-compare PWM channels with shared dead-time,
// sync-loaded shadow references and a global fault latch.
//
// Configuration macro: PWM_MIN_PULSE_EN adds the min_pulse port and a
// per-channel raw glitch filter.
//
// Ports:
//   clk, rst       clock, asynchronous active-high reset
//   enable         global run; low forces every channel OFF
//   sync           strobe at carrier peak/valley; loads shadow references
//   reference      packed signed references, channel k at [k*DATA_WIDTH +: DATA_WIDTH]
//   carrier        packed signed carriers, same packing
//   deadtime       dead-time in clk cycles, shared
//   min_pulse      minimum accepted pulse width (PWM_MIN_PULSE_EN only)
//   fault_in       level fault request
//   fault_clr      single-cycle fault clear request
//   pwm_high       high-side gate drives
//   pwm_low        low-side gate drives
//   dt_active      per-channel DEAD indication
//   fault_latched  fault latch state
module pwm_deadtime_array
    import pwm_pkg::*;
#(
    parameter int unsigned N_CH       = PWM_N_CH_DEF,
    parameter int unsigned DATA_WIDTH = PWM_DATA_WIDTH_DEF,
    parameter int unsigned DT_WIDTH   = PWM_DT_WIDTH_DEF
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         enable,
    input  logic                         sync,
    input  logic [N_CH*DATA_WIDTH-1:0]   reference,
    input  logic [N_CH*DATA_WIDTH-1:0]   carrier,
    input  logic [DT_WIDTH-1:0]          deadtime,
`ifdef PWM_MIN_PULSE_EN
    input  logic [DT_WIDTH-1:0]          min_pulse,
`endif
    input  logic                         fault_in,
    input  logic                         fault_clr,
    output logic [N_CH-1:0]              pwm_high,
    output logic [N_CH-1:0]              pwm_low,
    output logic [N_CH-1:0]              dt_active,
    output logic                         fault_latched
);

    logic [N_CH*DATA_WIDTH-1:0] shadow_q;
    logic [N_CH-1:0]            cmp_c;
    logic [N_CH-1:0]            raw_q;
    logic                       force_off_c;

    // Shadow references only move on an enabled sync strobe.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shadow_q <= '0;
        end else if (enable && sync) begin
            shadow_q <= reference;
        end
    end

    // Registered compare; cleared while disabled.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            raw_q <= '0;
        end else if (!enable) begin
            raw_q <= '0;
        end else begin
            raw_q <= cmp_c;
        end
    end

    // Set has priority over clear; enable does not touch the latch.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fault_latched <= 1'b0;
        end else if (fault_in) begin
            fault_latched <= 1'b1;
        end else if (fault_clr) begin
            fault_latched <= 1'b0;
        end
    end

    // fault_in is used directly (not only via the latch) so the bridge is
    // switched off on the very edge that first sees the fault.
    assign force_off_c = !enable || fault_in || fault_latched;

    for (genvar k = 0; k < N_CH; k++) begin : g_ch
        logic signed [DATA_WIDTH-1:0] shadow_s;
        logic signed [DATA_WIDTH-1:0] carrier_s;

        assign shadow_s  = shadow_q[k*DATA_WIDTH +: DATA_WIDTH];
        assign carrier_s = carrier[k*DATA_WIDTH +: DATA_WIDTH];
        // Strict greater-than: equality keeps the high side off.
        assign cmp_c[k]  = (shadow_s > carrier_s);

        pwm_dt_channel #(
            .DT_WIDTH (DT_WIDTH)
        ) u_ch (
            .clk       (clk),
            .rst       (rst),
            .force_off (force_off_c),
            .raw       (raw_q[k]),
            .deadtime  (deadtime),
`ifdef PWM_MIN_PULSE_EN
            .min_pulse (min_pulse),
`endif
            .pwm_high  (pwm_high[k]),
            .pwm_low   (pwm_low[k]),
            .dt_active (dt_active[k])
        );
    end

endmodule : pwm_deadtime_array

// File: doc/pwm_deadtime_array.md
PWM_DEADTIME_ARRAY -- requirements
Module: pwm_deadtime_array

Interface
REQ-001 Parameter N_CH, default 2, number of independent comparator/dead-time channels (one per H-bridge).
REQ-002 Parameter DATA_WIDTH, default 16, signed width of reference and carrier samples.
REQ-003 Parameter DT_WIDTH, default 10, width of dead-time and min-pulse counters.
REQ-004 Port clk  input  1  system clock; the block uses one clock.
REQ-005 Port rst  input  1  reset, asynchronous and active-high.
REQ-006 Port enable  input  1  global run; low forces the safe state.
REQ-007 Port sync  input  1  single-cycle strobe at carrier peak/valley that loads shadow references.
REQ-008 Port reference  input  N_CH*DATA_WIDTH  packed signed references; channel k occupies bits [k*DATA_WIDTH +: DATA_WIDTH].
REQ-009 Port carrier  input  N_CH*DATA_WIDTH  packed signed carriers, same packing.
REQ-010 Port deadtime  input  DT_WIDTH  dead-time in clk cycles, shared by all channels.
REQ-011 Port min_pulse  input  DT_WIDTH  minimum accepted pulse width in cycles; present only with PWM_MIN_PULSE_EN.
REQ-012 Port fault_in  input  1  asynchronous-source fault request, level sensitive.
REQ-013 Port fault_clr  input  1  single-cycle fault clear request.
REQ-014 Port pwm_high  output  N_CH  high-side gate drives.
REQ-015 Port pwm_low  output  N_CH  low-side gate drives.
REQ-016 Port dt_active  output  N_CH  channel is currently in DEAD.
REQ-017 Port fault_latched  output  1  fault latch state.

Function
REQ-018 Shadow reference per channel SHALL load from reference only on cycles with sync=1 and enable=1; the comparator SHALL use only the shadow value.
REQ-019 Raw compare SHALL be registered: raw[k] <= (shadow[k] > carrier[k]), signed; equality gives 0; one-cycle latency.
REQ-020 Each channel SHALL run an FSM with states OFF, HIGH, LOW, DEAD; outputs: OFF and DEAD both 0; HIGH = (1,0); LOW = (0,1); outputs registered.
REQ-021 OFF -> DEAD (target = raw) on the first enabled cycle with no fault; counter loaded with deadtime.
REQ-022 HIGH/LOW -> DEAD when accepted raw differs from current state; counter loaded with deadtime, target latched.
REQ-023 DEAD SHALL last exactly deadtime cycles, then enter the target state; deadtime=0 SHALL switch HIGH<->LOW directly with no all-low cycle.
REQ-024 If raw changes during DEAD, target SHALL update and the counter SHALL reload (both outputs stay 0).
REQ-025 High and low outputs of a channel SHALL never be 1 simultaneously, under any input sequence.
REQ-026 A change of deadtime mid-DEAD SHALL take effect only at the next DEAD entry.
REQ-027 fault_in=1 SHALL set fault_latched on the next edge and force every channel to OFF in the same cycle; fault_clr with fault_in=0 clears the latch; fault_clr with fault_in=1 is ignored; fault set wins over clear.
REQ-028 enable=0 SHALL force all channels to OFF and clear raw and counters, but SHALL NOT clear fault_latched.

Reset
REQ-029 On rst=1 all pwm_high, pwm_low, dt_active = 0, fault_latched = 0, shadows = 0, FSMs = OFF, counters = 0, immediately and asynchronously.
REQ-030 Reset asserted mid-DEAD or mid-pulse SHALL drive outputs low without waiting for a clock edge; release SHALL resume from OFF.

Configuration
REQ-031 Macro PWM_MIN_PULSE_EN: when defined, a raw change SHALL be accepted only after it holds for min_pulse consecutive cycles (min_pulse=0 or 1 means no filtering), adding that many cycles of latency; when undefined, the min_pulse port and filter are absent and every raw change is accepted immediately.

Structure
REQ-032 Shared package pwm_pkg SHALL hold the channel state encoding (OFF, HIGH, LOW, DEAD) and default width constants.
REQ-033 The per-channel FSM, counter and filter SHALL live in sub-module pwm_dt_channel, instantiated N_CH times by generate.

Verification
REQ-034 deadtime=100, ref 0x2000 vs triangle carrier: each edge shows exactly 100 all-low cycles; high and low are never both 1.
REQ-035 deadtime=0: HIGH->LOW on the cycle after the raw change, with no all-low cycle.
REQ-036 reference changed without sync: duty unchanged until the next sync pulse, then updated.
REQ-037 fault_in pulse during HIGH: outputs 0 the next cycle, fault_latched=1; fault_clr while fault_in=1 is ignored, then clears after fault_in=0, and the channel re-enters through DEAD.
REQ-038 PWM_MIN_PULSE_EN, min_pulse=5: 3-cycle raw glitch is suppressed; 6-cycle pulse is accepted 5 cycles late.
REQ-039 rst asserted mid-DEAD with N_CH=4: all outputs 0 asynchronously; after release all channels are OFF and restart cleanly.
